// File: rtl/regfile_mux_nport.sv
// Register file with NUM_RD read ports, one write port and an optional hardwired zero register.
// Defining REGFILE_WR_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_mux_nport #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 64,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 31,
  parameter int REG_OUT  = 0,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);

  // An index is live when it names real storage other than the zero register.
  function automatic logic addr_live(input logic [ADDR_W-1:0] addr);
    return (int'(addr) < NUM_REGS) && (int'(addr) != ZERO_REG);
  endfunction

  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic [ADDR_W-1:0]        rd_idx [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] sel_flat;
  logic                     wr_ok;

  assign wr_ok = reset_n && wr_en && addr_live(wr_addr);

  for (genvar p = 0; p < NUM_RD; p++) begin : g_idx
    assign rd_idx[p] = rd_addr[p*ADDR_W +: ADDR_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Dead indices (zero register, out of range) select the constant-zero leg of each port's mux.
  always_comb begin
    sel_flat = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (addr_live(rd_idx[p])) begin
        sel_flat[p*DATA_W +: DATA_W] = regs[rd_idx[p]];
      end
`ifdef REGFILE_WR_BYPASS_EN
      if (wr_ok && (rd_idx[p] == wr_addr)) begin
        sel_flat[p*DATA_W +: DATA_W] = wr_data;
      end
`endif
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [NUM_RD*DATA_W-1:0] rd_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_q <= '0;
      end else begin
        rd_q <= sel_flat;
      end
    end

    assign rd_data = rd_q;
  end else begin : g_comb_out
    assign rd_data = sel_flat;
  end

endmodule

// File: tb/tb_regfile_mux_nport.sv
// Scoreboard bench: a combinational 32x64 two-port instance and a registered 24x16 three-port
// instance (zero register 20) are driven together and checked against array models.
module tb_regfile_mux_nport;
  localparam int AW    = 5;
  localparam int DWC   = 64;
  localparam int NRC   = 2;
  localparam int DWR   = 16;
  localparam int NRR   = 3;
  localparam int NREGR = 24;
  localparam int ZR    = 20;

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic                wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic [DWC-1:0]      wr_data = '0;
  logic [NRC*AW-1:0]   rd_addr_c = '0;
  logic [NRC*DWC-1:0]  rd_data_c;
  logic [NRR*AW-1:0]   rd_addr_r = '0;
  logic [NRR*DWR-1:0]  rd_data_r;

  int n_checks = 0;
  int n_fail = 0;
  bit bypass_on = 1'b0;

  logic [DWC-1:0] mod_c [32];
  logic [DWR-1:0] mod_r [NREGR];
  logic [NRC*DWC-1:0] q_c [$];
  logic [NRR*DWR-1:0] q_r [$];

  always #5 clk = ~clk;

  regfile_mux_nport #(.NUM_REGS(32), .DATA_W(DWC), .NUM_RD(NRC), .ZERO_REG(31), .REG_OUT(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr_c), .rd_data(rd_data_c)
  );

  regfile_mux_nport #(.NUM_REGS(NREGR), .DATA_W(DWR), .NUM_RD(NRR), .ZERO_REG(ZR), .REG_OUT(1)) dut_r (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[DWR-1:0]),
    .rd_addr(rd_addr_r), .rd_data(rd_data_r)
  );

  function automatic logic [DWC-1:0] ref_c(input int a);
    return (a == 31) ? '0 : mod_c[a];
  endfunction

  function automatic logic [DWR-1:0] ref_r(input int a);
    return (a >= NREGR || a == ZR) ? '0 : mod_r[a];
  endfunction

  task automatic check_output(input string name, input logic [DWC-1:0] actual, input logic [DWC-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mod_c[i] = '0;
    for (int i = 0; i < NREGR; i++) mod_r[i] = '0;
  endtask

  // Drives one cycle of inputs and queues what each instance must show for it.
  task automatic apply_stimulus(input logic we, input int wa, input logic [DWC-1:0] wd,
                                input int ca0, input int ca1,
                                input int ra0, input int ra1, input int ra2);
    logic [NRC*DWC-1:0] ec;
    logic [NRR*DWR-1:0] er;
    int ca [NRC];
    int ra [NRR];
    ca[0] = ca0; ca[1] = ca1;
    ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
    @(negedge clk); #1;
    wr_en     = we;
    wr_addr   = AW'(wa);
    wr_data   = wd;
    rd_addr_c = {AW'(ca1), AW'(ca0)};
    rd_addr_r = {AW'(ra2), AW'(ra1), AW'(ra0)};
    for (int p = 0; p < NRC; p++)
      ec[p*DWC +: DWC] = (bypass_on && we && wa == ca[p] && wa != 31) ? wd : ref_c(ca[p]);
    for (int p = 0; p < NRR; p++)
      er[p*DWR +: DWR] = (bypass_on && we && wa == ra[p] && wa < NREGR && wa != ZR) ? wd[DWR-1:0] : ref_r(ra[p]);
    q_c.push_back(ec);
    q_r.push_back(er);
    if (we && wa != 31) mod_c[wa] = wd;
    if (we && wa < NREGR && wa != ZR) mod_r[wa] = wd[DWR-1:0];
  endtask

  task automatic check_all_zero(input string tag);
    for (int p = 0; p < NRC; p++)
      check_output($sformatf("%s_comb_p%0d", tag, p), rd_data_c[p*DWC +: DWC], '0);
    for (int p = 0; p < NRR; p++)
      check_output($sformatf("%s_reg_p%0d", tag, p), DWC'(rd_data_r[p*DWR +: DWR]), '0);
  endtask

  // Mid-cycle reset pulse: outputs must drop to zero with no clock edge.
  task automatic pulse_reset();
    @(posedge clk); #2;
    wr_en = 1'b0;
    rd_addr_c = {AW'(5), AW'(5)};
    rd_addr_r = {AW'(5), AW'(5), AW'(5)};
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    clear_model();
    #1 reset_n = 1'b1;
  endtask

  // Monitor: comb results just before each rising edge, registered results just after.
  initial begin
    logic [NRC*DWC-1:0] exp_c;
    logic [NRR*DWR-1:0] exp_r;
    forever begin
      @(negedge clk); #4;
      if (q_c.size() > 0) begin
        exp_c = q_c.pop_front();
        for (int p = 0; p < NRC; p++)
          check_output($sformatf("comb_p%0d", p), rd_data_c[p*DWC +: DWC], exp_c[p*DWC +: DWC]);
      end
      @(posedge clk); #1;
      if (q_r.size() > 0) begin
        exp_r = q_r.pop_front();
        for (int p = 0; p < NRR; p++)
          check_output($sformatf("reg_p%0d", p), DWC'(rd_data_r[p*DWR +: DWR]), DWC'(exp_r[p*DWR +: DWR]));
      end
    end
  end

  initial begin
    int wa, c0, c1, r0, r1, r2;
    logic we;
    logic [DWC-1:0] wd;
`ifdef REGFILE_WR_BYPASS_EN
    bypass_on = 1'b1;
`endif
    clear_model();
    #1 reset_n = 1'b0;
    #1 check_all_zero("reset_state");
    #10 reset_n = 1'b1;

    // Write 0xDEAD to r5, read it back, then reset mid-cycle and read r5 again.
    apply_stimulus(1'b1, 5, 64'hDEAD, 0, 1, 0, 1, 2);
    apply_stimulus(1'b0, 0, 64'h0, 5, 5, 5, 5, 5);
    pulse_reset();
    apply_stimulus(1'b0, 0, 64'h0, 5, 5, 5, 5, 5);

    // Walking ones, then read back with mirrored addressing.
    for (int i = 0; i < 32; i++)
      apply_stimulus(1'b1, i, 64'h1 << i, i, 31 - i, i, 31 - i, 0);
    for (int i = 0; i < 32; i++)
      apply_stimulus(1'b0, 0, 64'h0, i, 31 - i, i, 31 - i, (i + 7) % 32);

    // Writes to the zero register (31 for comb, 20 for registered) are ignored.
    apply_stimulus(1'b1, 31, '1, 31, 31, 31, 20, 31);
    apply_stimulus(1'b1, 20, '1, 31, 20, 20, 20, 20);
    apply_stimulus(1'b0, 0, 64'h0, 31, 20, 20, 31, 20);

    // Same-cycle read of a register being written.
    apply_stimulus(1'b1, 7, 64'h11, 0, 0, 0, 0, 0);
    apply_stimulus(1'b1, 7, 64'h22, 7, 7, 7, 7, 7);
    apply_stimulus(1'b0, 0, 64'h0, 7, 7, 7, 7, 7);

    // Registered-read latency: switch address from r3 to r4 on consecutive cycles.
    apply_stimulus(1'b1, 3, 64'hAA, 0, 0, 0, 0, 0);
    apply_stimulus(1'b1, 4, 64'hBB, 0, 0, 0, 0, 0);
    apply_stimulus(1'b0, 0, 64'h0, 3, 4, 3, 3, 3);
    apply_stimulus(1'b0, 0, 64'h0, 4, 3, 4, 4, 4);

    // Out-of-range write on the 24-entry instance.
    apply_stimulus(1'b1, 25, 64'h5, 25, 24, 25, 24, 31);
    apply_stimulus(1'b0, 0, 64'h0, 25, 1, 25, 23, 1);

    // Randomized traffic, biased so reads often hit the write address.
    for (int k = 0; k < 300; k++) begin
      if (k == 150) pulse_reset();
      we = 1'($urandom_range(0, 1));
      wa = $urandom_range(0, 31);
      wd = {$urandom, $urandom};
      c0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      c1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      r0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      r1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      r2 = $urandom_range(0, 31);
      apply_stimulus(we, wa, wd, c0, c1, r0, r1, r2);
    end

    @(posedge clk); #3;
    check_output("drain_comb_queue", DWC'(q_c.size()), '0);
    check_output("drain_reg_queue", DWC'(q_r.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
